// File: rtl/boss_palette_arbiter.sv
// Round-robin share of the boss palette lookup among up to four sprite requesters.
// Registers the looked-up colour with the winner's ID and runs the damage-flash FSM.
//
// Ports:
//   Clk, Reset          clock, async active-high reset
//   req[NUM_REQ]        per-requester level request
//   idx[4*NUM_REQ]      palette index per requester (k uses [4k+3:4k])
//   en                  arbitration enable
//   flash_start         pulse: start/restart damage flash
//   gnt[NUM_REQ]        one-hot grant (combinational)
//   pal_index[4]        index to palette ROM (combinational)
//   pal_red/green/blue  ROM result for pal_index, same cycle
//   rgb[12], rgb_valid, rgb_id[2]   registered result
//   flashing            registered, high while in FLASH
module boss_palette_arbiter #(
  parameter int          NUM_REQ      = 4,
  parameter logic [15:0] FLASH_CYCLES = 16'd50000
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [4*NUM_REQ-1:0]   idx,
  input  logic                   en,
  input  logic                   flash_start,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [3:0]             pal_index,
  input  logic [3:0]             pal_red,
  input  logic [3:0]             pal_green,
  input  logic [3:0]             pal_blue,
  output logic [11:0]            rgb,
  output logic                   rgb_valid,
  output logic [1:0]             rgb_id,
  output logic                   flashing
);

  typedef enum logic {
    IDLE  = 1'b0,
    FLASH = 1'b1
  } state_t;

  localparam logic [3:0] FLASH_IDX = 4'd7;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_cnt;
  logic [15:0] w_cnt_nxt;
  logic [1:0]  r_ptr;
  logic [1:0]  w_ptr_nxt;
  logic        w_any;
  logic [1:0]  w_win;
  logic [3:0]  w_raw_idx;

  // First asserted request at or after the pointer, wrapping modulo NUM_REQ.
  always_comb begin
    w_any = 1'b0;
    w_win = 2'd0;
    if (en) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!w_any && req[(int'(r_ptr) + i) % NUM_REQ]) begin
          w_any = 1'b1;
          w_win = 2'((int'(r_ptr) + i) % NUM_REQ);
        end
      end
    end
  end

  always_comb begin
    gnt = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      gnt[k] = w_any && (int'(w_win) == k);
    end
  end

  assign w_raw_idx = idx[4*int'(w_win) +: 4];

  // Index 0 is the transparency key and passes through unchanged.
  always_comb begin
    pal_index = 4'd0;
    if (w_any) begin
      pal_index = w_raw_idx;
      if (w_win == 2'd0 && r_state == FLASH && w_raw_idx != 4'd0) begin
        pal_index = FLASH_IDX;
      end
    end
  end

  always_comb begin
    w_ptr_nxt = r_ptr;
    if (w_any) begin
      w_ptr_nxt = 2'((int'(w_win) + 1) % NUM_REQ);
    end
  end

  // Retrigger takes priority over expiry; cnt never goes below zero.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      IDLE: begin
        if (flash_start) begin
          w_state_nxt = FLASH;
          w_cnt_nxt   = FLASH_CYCLES - 16'd1;
        end
      end
      FLASH: begin
        if (flash_start) begin
          w_cnt_nxt = FLASH_CYCLES - 16'd1;
        end else if (r_cnt == 16'd0) begin
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 16'd1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = 16'd0;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= IDLE;
      r_cnt   <= 16'd0;
      r_ptr   <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  // flashing mirrors the state register, loaded from the same next-state.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      flashing <= 1'b0;
    end else begin
      flashing <= (w_state_nxt == FLASH);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rgb       <= 12'd0;
      rgb_id    <= 2'd0;
      rgb_valid <= 1'b0;
    end else begin
      rgb_valid <= w_any;
      if (w_any) begin
        rgb    <= {pal_red, pal_green, pal_blue};
        rgb_id <= w_win;
      end
    end
  end

endmodule

// File: doc/boss_palette_arbiter.md
# boss_palette_arbiter

Shares the single combinational boss palette lookup (4-bit index → 12-bit RGB) among up to four sprite pixel requesters: boss body, boss turret, boss projectiles and HUD boss icon. It arbitrates round-robin, one grant per cycle, and registers the returned colour with the winner's ID. It also runs a damage-flash state machine that, for a programmable duration, remaps requester 0's non-transparent pixels to palette entry 7 (white). It sits between the sprite fetch units and the colour mapper.

## Interface
- NUM_REQ, 4: number of requesters; legal range 2–4.
- FLASH_CYCLES, 16'd50000: flash duration in Clk cycles; must be ≥1.
- Clk  in  1  system clock; all state on rising edge.
- Reset  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  per-requester request, level.
- idx  in  4*NUM_REQ  palette index per requester; requester k uses bits [4k+3:4k].
- en  in  1  arbitration enable; low forces no grants.
- flash_start  in  1  single-cycle pulse; starts or restarts the flash.
- gnt  out  NUM_REQ  one-hot grant, combinational, same cycle as the winning req.
- pal_index  out  4  index to the palette ROM, combinational.
- pal_red, pal_green, pal_blue  in  4 each  palette ROM result for pal_index, same cycle.
- rgb  out  12  registered colour {R,G,B}.
- rgb_valid  out  1  registered; rgb/rgb_id hold a result.
- rgb_id  out  2  registered; index of the requester that produced rgb.
- flashing  out  1  registered; high while the FSM is in FLASH.

## Operation
- Arbitration: a round-robin pointer `ptr` (2 bits, reset 0) picks the first asserted req at or after `ptr`, wrapping modulo NUM_REQ.
- If en=0 or no req is asserted, gnt=0 and pal_index=0.
- On a grant to requester k, `ptr` becomes (k+1) mod NUM_REQ. With no grant, `ptr` holds.
- Handshake: a requester holds req and idx stable until it sees gnt. It may drop req or present a new idx in the following cycle. A requester that keeps req high is re-arbitrated each cycle, one grant per request-cycle.
- pal_index is the winner's idx. If the winner is k=0, FSM state is FLASH and idx≠0, pal_index is forced to 4'd7. Index 0 is the transparency key and is never remapped.
- Output register: on a grant, rgb ← {pal_red,pal_green,pal_blue}, rgb_id ← k, rgb_valid ← 1. With no grant, rgb_valid ← 0 and rgb/rgb_id hold their previous values.
- FSM, two states:
  - IDLE: flash_start moves to FLASH and loads `cnt` ← FLASH_CYCLES−1.
  - FLASH: decrements `cnt` each cycle. Moves to IDLE in the cycle `cnt`=0 is observed. flash_start in FLASH reloads `cnt` (retrigger), and retrigger wins over expiry in the same cycle.
  - `cnt` width is 16 bits, with no wrap (it never decrements below 0).
- flashing is registered from the state, so it reads 1 from the cycle after flash_start.
- Remapping uses the current (registered) state. A grant in the same cycle as flash_start is not remapped.

## Timing
- Reset values: ptr=0, state=IDLE, cnt=0, rgb=0, rgb_id=0, rgb_valid=0, flashing=0. gnt and pal_index follow inputs combinationally (0 while en=0).
- Latency: req in cycle N produces gnt in cycle N, and rgb/rgb_valid in cycle N+1.
- Throughput: one result per cycle. With all NUM_REQ requesters continuously asserted, each is granted exactly once every NUM_REQ cycles.
- Flash length: exactly FLASH_CYCLES cycles of flashing=1 after a single flash_start with no retrigger.
- Reset mid-operation clears everything asynchronously; the first grant after deassertion goes to the lowest asserted index ≥0.

## Test plan
- Reset with req=4'b1111 held, en=1 → gnt sequence 0001,0010,0100,1000,0001; rgb_id 0,1,2,3 one cycle later; rgb_valid stays 1.
- req=4'b0100, idx[11:8]=4'd4 → gnt=0100, pal_index=4; next cycle rgb=12'hE03, rgb_id=2, rgb_valid=1.
- Grant to 3, then req=4'b1001 → grant 0 (wrap), then grant 3; en=0 with req set → gnt=0 and rgb_valid=0 next cycle.
- FLASH_CYCLES=4, flash_start pulse, req0 with idx=4'd3 → flashing=1 for exactly 4 cycles; pal_index=7 and rgb=12'hFFF during those cycles; idx=0 still gives rgb=12'hA4A; req1 idx=3 gives 12'hF94 throughout.
- Retrigger flash_start in the cycle cnt=0 → remains in FLASH for 4 more cycles (8 total).
- Assert Reset asynchronously mid-flash with req active → flashing, rgb_valid and rgb clear immediately; after release, ptr=0.
